// File: rtl/tpu_controller.sv
// rtl/tpu_controller.sv - instruction sequencer driving buffer, FIFO, MMU and accumulator strobes
module tpu_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128,
  parameter int ROWS   = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] host_din,
  input  logic              host_din_valid,
  output logic              host_din_ready,
  output logic              write_data,
  output logic              write_weight,
  output logic              read_en,
  output logic              load_weight,
  output logic              mat_mul,
  output logic              write_result,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Wide enough for N (up to 256) plus read latency and the drain tail.
  localparam int CW = 16;

  localparam logic [3:0] OP_WRITE_DATA   = 4'd1;
  localparam logic [3:0] OP_WRITE_WEIGHT = 4'd2;
  localparam logic [3:0] OP_LOAD_WEIGHT  = 4'd3;
  localparam logic [3:0] OP_MAT_MUL      = 4'd4;
  localparam logic [3:0] OP_WRITE_RESULT = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_RES,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     n_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addra_q, addrb_q;
  logic [DATA_W-1:0] dout_q;
  logic              accept, cnt_inc;
  logic [CW-1:0]     lw_end, mm_end;
  logic [ADDR_W-1:0] row_addr;
  logic [3:0]        new_op;
  logic              unused_rsvd;

  assign new_op      = instruction[31:28];
  assign unused_rsvd = ^instruction[11:0];
  assign busy        = (state_q != S_IDLE);
  assign row_addr    = base_q + ADDR_W'(cnt_q);

  // Last cycle index of the weight load (reads plus the BRAM latency tail).
  assign lw_end = n_q - CW'(1) + CW'(RD_LAT);
  // Last mat_mul cycle: last data row arrives, then 2*ROWS-1 drain cycles.
  assign mm_end = n_q + CW'(RD_LAT) + CW'(2 * ROWS) - CW'(2);

  // State, decoded instruction fields, row counter and held address/data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      base_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      addra_q <= '0;
      addrb_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= new_op;
        base_q <= ADDR_W'(instruction[27:20]);
        n_q    <= CW'(instruction[19:12]) + CW'(1);
        cnt_q  <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CW'(1);
      end
      addra_q <= addra;
      addrb_q <= addrb;
      dout_q  <= dout;
    end
  end

  // Next-state decode and per-state strobes; addresses track the active row and hold otherwise.
  always_comb begin
    state_d        = state_q;
    instr_ready    = 1'b0;
    host_din_ready = 1'b0;
    write_data     = 1'b0;
    write_weight   = 1'b0;
    read_en        = 1'b0;
    load_weight    = 1'b0;
    mat_mul        = 1'b0;
    write_result   = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    accept         = 1'b0;
    cnt_inc        = 1'b0;
    addra          = addra_q;
    addrb          = addrb_q;
    dout           = dout_q;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept = 1'b1;
          case (new_op)
            OP_WRITE_DATA, OP_WRITE_WEIGHT: state_d = S_WR;
            OP_LOAD_WEIGHT, OP_MAT_MUL:     state_d = S_RD;
            OP_WRITE_RESULT:                state_d = S_RES;
            default:                        state_d = S_FIN;
          endcase
        end
      end
      S_WR: begin
        host_din_ready = 1'b1;
        if (host_din_valid) begin
          write_data   = (op_q == OP_WRITE_DATA);
          write_weight = (op_q != OP_WRITE_DATA);
          addra        = row_addr;
          dout         = host_din;
          cnt_inc      = 1'b1;
          if (cnt_q == n_q - CW'(1)) state_d = S_FIN;
        end
      end
      S_RD: begin
        read_en = (cnt_q < n_q);
        if (read_en) addrb = row_addr;
        cnt_inc = 1'b1;
        if (op_q == OP_LOAD_WEIGHT) begin
          load_weight = (cnt_q >= CW'(RD_LAT));
          if (cnt_q == lw_end) state_d = S_FIN;
        end else begin
          mat_mul = (cnt_q >= CW'(RD_LAT));
          if (cnt_q == n_q - CW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        mat_mul = (cnt_q >= CW'(RD_LAT));
        cnt_inc = 1'b1;
        if (cnt_q == mm_end) state_d = S_FIN;
      end
      S_RES: begin
        write_result = 1'b1;
        cnt_inc      = 1'b1;
        if (cnt_q == CW'(ROWS - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        err     = (op_q > OP_WRITE_RESULT);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
